backtrack_unit: RTL and testbench

Conflict-driven backtrack sequencer that sits directly downstream of the trace table in the DPLL core. On a conflict it pops assignment entries off the trace table and unassigns every forced entry. At the first decide entry it stops, unassigns nothing, and pushes that variable back as a forced entry with the opposite value. If the stack empties without reaching a decide entry, it reports the formula unsatisfiable.

---
 rtl/backtrack_unit.sv | 189 ++++++++++++++++++
 tb/tb_backtrack_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backtrack_unit.sv
// Conflict backtrack sequencer: pops trace-table entries, unassigns forced ones, flips the first decide.
// Optional pop counter on pop_count is built only when BACKTRACK_STATS_EN is defined.
module backtrack_unit #(
  parameter int  NUM_VARIABLE     = 128,
  parameter int  VARIABLE_INDEXES = 8,
  localparam int VW               = VARIABLE_INDEXES + 1,
  localparam int CW               = $clog2(NUM_VARIABLE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          unsat,
  output logic          tt_en,
  output logic          tt_rw,
  output logic          tt_type,
  output logic          tt_val,
  output logic [VW-1:0] tt_variable,
  input  logic          tt_type_out,
  input  logic          tt_val_out,
  input  logic [VW-1:0] tt_variable_out,
  input  logic          tt_empty,
  output logic          unassign_en,
  output logic [VW-1:0] unassign_var,
  output logic          assign_en,
  output logic [VW-1:0] assign_var,
  output logic          assign_val,
  output logic [CW-1:0] pop_count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_CHECK  = 3'd2,
    S_PUSH   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Handshake: tt_en with tt_rw=0 requests a pop; the popped entry is valid
  // during the following CHECK cycle. tt_en with tt_rw=1 pushes tt_* for one cycle.

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            unsat_q, unsat_d;
  logic            tt_en_q, tt_en_d;
  logic            tt_rw_q, tt_rw_d;
  logic            tt_type_q, tt_type_d;
  logic            tt_val_q, tt_val_d;
  logic [VW-1:0]   tt_var_q, tt_var_d;
  logic            assign_en_q, assign_en_d;
  logic [VW-1:0]   assign_var_q, assign_var_d;
  logic            assign_val_q, assign_val_d;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unsat_d      = 1'b0;
    tt_en_d      = 1'b0;
    tt_rw_d      = 1'b0;
    tt_type_d    = 1'b0;
    tt_val_d     = 1'b0;
    tt_var_d     = '0;
    assign_en_d  = 1'b0;
    assign_var_d = '0;
    assign_val_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (tt_empty) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            unsat_d = 1'b1;
          end else begin
            state_d = S_POP;
            tt_en_d = 1'b1;
          end
        end
      end
      S_POP: state_d = S_CHECK;
      S_CHECK: begin
        if (tt_type_out) begin
          if (tt_empty) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            unsat_d = 1'b1;
          end else begin
            state_d = S_POP;
            tt_en_d = 1'b1;
          end
        end else begin
          // Decide entry: re-push it as forced with the opposite polarity.
          state_d      = S_PUSH;
          tt_en_d      = 1'b1;
          tt_rw_d      = 1'b1;
          tt_type_d    = 1'b1;
          tt_val_d     = ~tt_val_out;
          tt_var_d     = tt_variable_out;
          assign_en_d  = 1'b1;
          assign_var_d = tt_variable_out;
          assign_val_d = ~tt_val_out;
        end
      end
      S_PUSH: begin
        state_d = S_FINISH;
        done_d  = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      unsat_q      <= 1'b0;
      tt_en_q      <= 1'b0;
      tt_rw_q      <= 1'b0;
      tt_type_q    <= 1'b0;
      tt_val_q     <= 1'b0;
      tt_var_q     <= '0;
      assign_en_q  <= 1'b0;
      assign_var_q <= '0;
      assign_val_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      unsat_q      <= unsat_d;
      tt_en_q      <= tt_en_d;
      tt_rw_q      <= tt_rw_d;
      tt_type_q    <= tt_type_d;
      tt_val_q     <= tt_val_d;
      tt_var_q     <= tt_var_d;
      assign_en_q  <= assign_en_d;
      assign_var_q <= assign_var_d;
      assign_val_q <= assign_val_d;
    end
  end

  // The popped entry is only valid during CHECK, so the unassign pulse follows it directly.
  assign unassign_en  = (state_q == S_CHECK) && tt_type_out;
  assign unassign_var = unassign_en ? tt_variable_out : '0;

  assign busy        = busy_q;
  assign done        = done_q;
  assign unsat       = unsat_q;
  assign tt_en       = tt_en_q;
  assign tt_rw       = tt_rw_q;
  assign tt_type     = tt_type_q;
  assign tt_val      = tt_val_q;
  assign tt_variable = tt_var_q;
  assign assign_en   = assign_en_q;
  assign assign_var  = assign_var_q;
  assign assign_val  = assign_val_q;
  assign dbg_state   = state_q;

`ifdef BACKTRACK_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_VARIABLE);
  logic [CW-1:0] pop_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pop_count_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      pop_count_q <= '0;
    end else if (state_q == S_POP && pop_count_q != CNT_MAX) begin
      pop_count_q <= pop_count_q + 1'b1;
    end
  end

  assign pop_count = pop_count_q;
`else
  assign pop_count = '0;
`endif

endmodule

// File: tb/tb_backtrack_unit.sv
// Self-checking bench for backtrack_unit: behavioural trace table plus scoreboard queues.
module tb_backtrack_unit;
  localparam int VW = 9;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, unsat;
  logic          tt_en, tt_rw, tt_type, tt_val;
  logic [VW-1:0] tt_variable;
  logic          tt_type_out, tt_val_out;
  logic [VW-1:0] tt_variable_out;
  logic          tt_empty;
  logic          unassign_en, assign_en, assign_val;
  logic [VW-1:0] unassign_var, assign_var;
  logic [CW-1:0] pop_count;
  logic [2:0]    dbg_state;

  backtrack_unit dut (
    .clock(clk), .reset(rst), .start(start), .busy(busy), .done(done), .unsat(unsat),
    .tt_en(tt_en), .tt_rw(tt_rw), .tt_type(tt_type), .tt_val(tt_val), .tt_variable(tt_variable),
    .tt_type_out(tt_type_out), .tt_val_out(tt_val_out), .tt_variable_out(tt_variable_out),
    .tt_empty(tt_empty), .unassign_en(unassign_en), .unassign_var(unassign_var),
    .assign_en(assign_en), .assign_var(assign_var), .assign_val(assign_val),
    .pop_count(pop_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  int cyc0 = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int n_pop = 0;
  int n_push = 0;
  logic [VW-1:0] exp_unassign_q[$];
  logic [VW:0]   exp_push_q[$];
  logic [24:0]   exp_done_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural trace table: pop/push serviced mid-cycle, read data valid next cycle
  logic          tb_type[0:255];
  logic          tb_val[0:255];
  logic [VW-1:0] tb_var[0:255];
  int            sp = 0;
  assign tt_empty = (sp == 0);

  always @(negedge clk) begin
    if (!rst && tt_en) begin
      if (!tt_rw) begin
        n_pop++;
        if (sp > 0) begin
          sp = sp - 1;
          tt_type_out     = tb_type[sp];
          tt_val_out      = tb_val[sp];
          tt_variable_out = tb_var[sp];
        end
      end else begin
        n_push++;
        tb_type[sp] = tt_type;
        tb_val[sp]  = tt_val;
        tb_var[sp]  = tt_variable;
        sp = sp + 1;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (unassign_en) begin
        if (exp_unassign_q.size() == 0) check_val("unassign_extra", 32'(unassign_var), 32'hFFFF_FFFF);
        else check_val("unassign_var", 32'(unassign_var), 32'(exp_unassign_q.pop_front()));
      end
      if (tt_en && tt_rw) begin
        if (exp_push_q.size() == 0) begin
          check_val("push_extra", 32'(tt_variable), 32'hFFFF_FFFF);
        end else begin
          logic [VW:0] e;
          e = exp_push_q.pop_front();
          check_val("push_var", 32'(tt_variable), 32'(e[VW:1]));
          check_val("push_val", 32'(tt_val), 32'(e[0]));
          check_val("push_type", 32'(tt_type), 32'd1);
          check_val("assign_en", 32'(assign_en), 32'd1);
          check_val("assign_var", 32'(assign_var), 32'(e[VW:1]));
          check_val("assign_val", 32'(assign_val), 32'(e[0]));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          check_val("done_extra", 32'(done), 32'd0);
        end else begin
          logic [24:0] d;
          d = exp_done_q.pop_front();
          check_val("done_cycle", 32'(cyc - cyc0), 32'(d[24:9]));
          check_val("unsat", 32'(unsat), 32'(d[8]));
          check_val("pop_count", 32'(pop_count), 32'(d[7:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic load_entry(input logic t, input logic v, input logic [VW-1:0] var_i);
    tb_type[sp] = t;
    tb_val[sp]  = v;
    tb_var[sp]  = var_i;
    sp = sp + 1;
  endtask

  task automatic run_case(input int restart_at);
    int m;
    int pops;
    int dcyc;
    int pc;
    int d0, p0, q0;
    bit found;
    logic [VW-1:0] top_var;
    logic top_val;
    m = 0;
    found = 1'b0;
    top_var = '0;
    top_val = 1'b0;
    for (int i = sp - 1; i >= 0; i--) begin
      if (!found) begin
        if (tb_type[i]) begin
          exp_unassign_q.push_back(tb_var[i]);
          m++;
        end else begin
          found = 1'b1;
          top_var = tb_var[i];
          top_val = ~tb_val[i];
          exp_push_q.push_back({tb_var[i], ~tb_val[i]});
        end
      end
    end
    pops = found ? m + 1 : m;
    dcyc = found ? 2 * pops + 2 : 2 * m + 1;
`ifdef BACKTRACK_STATS_EN
    pc = pops;
`else
    pc = 0;
`endif
    exp_done_q.push_back({16'(dcyc), ~found, 8'(pc)});
    d0 = done_cnt;
    p0 = n_pop;
    q0 = n_push;
    @(posedge clk); #1;
    start = 1'b1;
    cyc0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check_val("busy_rise", 32'(busy), 32'd1);
    if (restart_at > 1) begin
      repeat (restart_at - 1) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 600 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == d0) check_val("done_timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
    check_val("busy_fall", 32'(busy), 32'd0);
    check_val("idle_state", 32'(dbg_state), 32'd0);
    check_val("idle_tt_en", 32'(tt_en), 32'd0);
    check_val("idle_assign_en", 32'(assign_en), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_val("done_count", 32'(done_cnt - d0), 32'd1);
    check_val("pop_ops", 32'(n_pop - p0), 32'(pops));
    check_val("push_ops", 32'(n_push - q0), 32'(found));
    check_val("unassign_left", 32'(exp_unassign_q.size()), 32'd0);
    if (found) begin
      check_val("tbl_top_type", 32'(tb_type[sp-1]), 32'd1);
      check_val("tbl_top_var", 32'(tb_var[sp-1]), 32'(top_var));
      check_val("tbl_top_val", 32'(tb_val[sp-1]), 32'(top_val));
    end
    exp_unassign_q.delete();
    exp_push_q.delete();
    exp_done_q.delete();
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    start = 1'b0;
    tt_type_out = 1'b0;
    tt_val_out = 1'b0;
    tt_variable_out = '0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_unsat", 32'(unsat), 32'd0);
    check_val("rst_tt", 32'({tt_en, tt_rw, tt_type, tt_val, tt_variable}), 32'd0);
    check_val("rst_assign", 32'({assign_en, assign_val, assign_var, unassign_en, unassign_var}), 32'd0);
    check_val("rst_pop_count", 32'(pop_count), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single decide entry
    sp = 0;
    load_entry(1'b0, 1'b1, 9'd5);
    run_case(0);

    // decide 3/0, forced 7/1, forced 9/0 (bottom to top)
    sp = 0;
    load_entry(1'b0, 1'b0, 9'd3);
    load_entry(1'b1, 1'b1, 9'd7);
    load_entry(1'b1, 1'b0, 9'd9);
    run_case(0);

    // forced only: unsat
    sp = 0;
    load_entry(1'b1, 1'b1, 9'd2);
    load_entry(1'b1, 1'b0, 9'd4);
    run_case(0);

    // empty table
    sp = 0;
    run_case(0);

    // start re-pulsed while busy must be ignored
    sp = 0;
    load_entry(1'b0, 1'b1, 9'd300);
    load_entry(1'b1, 1'b1, 9'd11);
    load_entry(1'b1, 1'b0, 9'd12);
    run_case(3);

    // reset during CHECK of a 3-entry backtrack
    sp = 0;
    load_entry(1'b0, 1'b0, 9'd1);
    load_entry(1'b1, 1'b1, 9'd6);
    load_entry(1'b1, 1'b0, 9'd8);
    p0 = n_push;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_state", 32'(dbg_state), 32'd2);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_state", 32'(dbg_state), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_unassign", 32'(unassign_en), 32'd0);
    check_val("mid_rst_outs", 32'({done, unsat, tt_en, assign_en, tt_variable, pop_count}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("post_rst_state", 32'(dbg_state), 32'd0);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    check_val("post_rst_push", 32'(n_push - p0), 32'd0);

    // random tables
    for (int n = 0; n < 8; n++) begin
      int depth;
      sp = 0;
      depth = $urandom_range(0, 6);
      for (int j = 0; j < depth; j++)
        load_entry(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
      run_case(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
